// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard status inputs and stall/flush/counter outputs of the hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_rs1_ren;
    logic             id_rs2_ren;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             ex_valid;
    logic             ex_w_ena;
    logic [4:0]       ex_w_addr;
    logic             ex_mem_rd;
    logic             ex_redirect;
    logic             ex_mc_start;
    logic             ex_mc_done;
    logic             mem_wait;
    logic             if_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             mem_stall;
    logic             if_flush;
    logic             id_flush;
    logic             ex_bubble;
    logic             busy;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1_ren, id_rs2_ren, id_rs1_addr, id_rs2_addr,
               ex_valid, ex_w_ena, ex_w_addr, ex_mem_rd, ex_redirect,
               ex_mc_start, ex_mc_done, mem_wait,
        input  if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush,
               ex_bubble, busy, mc_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1_ren, id_rs2_ren, id_rs1_addr, id_rs2_addr,
               ex_valid, ex_w_ena, ex_w_addr, ex_mem_rd, ex_redirect,
               ex_mc_start, ex_mc_done, mem_wait,
        output if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush,
               ex_bubble, busy, mc_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler for the five-stage pipeline with event counters
module pipe_hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int MC_W = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MCWAIT, MEMWAIT} state_t;

    state_t           state;
    logic             busy_q;
    logic             redir_pend;
    logic [MC_W-1:0]  mc_cnt;
    logic             mc_timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic rule_mem;
    logic rule_mc;
    logic held;
    logic flush_now;
    logic load_use;
    logic lu_stall;
    logic if_stall_w;

    always_comb begin
        rule_mem  = hz.mem_wait;
        rule_mc   = ~rule_mem & ((state == MCWAIT) | hz.ex_mc_start);
        held      = rule_mem | rule_mc;
        flush_now = ~held & (hz.ex_redirect | redir_pend);
        load_use  = hz.ex_valid & hz.ex_mem_rd & hz.ex_w_ena & (hz.ex_w_addr != 5'd0) &
                    hz.id_valid &
                    ((hz.id_rs1_ren & (hz.id_rs1_addr == hz.ex_w_addr)) |
                     (hz.id_rs2_ren & (hz.id_rs2_addr == hz.ex_w_addr)));
        // A flushed ID instruction is a bubble anyway, so it cannot cause a load-use stall.
        lu_stall   = load_use & ~held & ~flush_now;
        if_stall_w = held | lu_stall;
    end

    assign hz.if_stall   = reset & if_stall_w;
    assign hz.id_stall   = reset & if_stall_w;
    assign hz.ex_stall   = reset & held;
    assign hz.mem_stall  = reset & rule_mem;
    assign hz.if_flush   = reset & flush_now;
    assign hz.id_flush   = reset & flush_now;
    assign hz.ex_bubble  = reset & lu_stall;
    assign hz.busy       = busy_q;
    assign hz.mc_timeout = mc_timeout_q;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            busy_q       <= 1'b0;
            redir_pend   <= 1'b0;
            mc_cnt       <= '0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            case (state)
                RUN, MEMWAIT: begin
                    // A cycle where mem_wait has dropped behaves like RUN, so a start there is taken.
                    if (hz.mem_wait) begin
                        state  <= MEMWAIT;
                        busy_q <= 1'b1;
                    end else if (hz.ex_mc_start) begin
                        state  <= MCWAIT;
                        busy_q <= 1'b1;
                        mc_cnt <= '0;
                    end else begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                MCWAIT: begin
                    if (mc_cnt != MC_W'(MC_TIMEOUT)) begin
                        mc_cnt <= mc_cnt + 1'b1;
                    end
                    if (mc_cnt == MC_W'(MC_TIMEOUT - 1)) begin
                        mc_timeout_q <= 1'b1;
                    end
                    if (hz.ex_mc_done) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase

            if (flush_now) begin
                redir_pend <= 1'b0;
            end else if (hz.ex_redirect & held) begin
                redir_pend <= 1'b1;
            end

            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, if_stall_w};
            flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_now};
        end
    end
endmodule
